// File: rtl/stream_sync_fifo_pkg.sv
// rtl/stream_sync_fifo_pkg.sv - shared depth derivation and threshold legality for the stream FIFO family
package stream_sync_fifo_pkg;

   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   function automatic bit af_lvl_legal(input int aw, input int af_lvl);
      return (af_lvl >= 1) && (af_lvl <= fifo_depth(aw));
   endfunction

   function automatic bit ae_lvl_legal(input int aw, input int ae_lvl);
      return (ae_lvl >= 0) && (ae_lvl <= fifo_depth(aw) - 1);
   endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// rtl/stream_fifo_mem.sv - simple dual-port RAM, one write port, registered read port, no reset
module stream_fifo_mem #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - first-word-fall-through synchronous stream FIFO with level and threshold flags
module stream_sync_fifo
   import stream_sync_fifo_pkg::*;
#(
   parameter int DW     = 8,
   parameter int AW     = 4,
   parameter int AF_LVL = (1 << AW) - 1,
   parameter int AE_LVL = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic [DW-1:0] stream_s_data_i,
   input  logic          stream_s_valid_i,
   output logic          stream_s_ready_o,
   output logic [DW-1:0] stream_m_data_o,
   output logic          stream_m_valid_o,
   input  logic          stream_m_ready_i,
   output logic [AW:0]   level_o,
   output logic          almost_full_o,
   output logic          almost_empty_o,
   output logic          overflow_o
);

   localparam int        DEPTH   = fifo_depth(AW);
   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] L_AF    = (AW+1)'(AF_LVL);
   localparam logic [AW:0] L_AE    = (AW+1)'(AE_LVL);

   if (!af_lvl_legal(AW, AF_LVL) || !ae_lvl_legal(AW, AE_LVL)) begin : g_bad_thresholds
      $error("stream_sync_fifo: AF_LVL must be 1..DEPTH and AE_LVL 0..DEPTH-1");
   end

   logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic [AW:0]   r_level, w_level_nxt;
   logic          r_s_ready, r_m_valid, r_af, r_ae, r_ovf;
   logic          r_byp;
   logic [DW-1:0] r_byp_data, w_mem_rdata;
   logic          w_wr, w_rd, w_byp;

   always_comb begin
      w_wr         = stream_s_valid_i && r_s_ready && !flush_i;
      w_rd         = r_m_valid && stream_m_ready_i && !flush_i;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_level_nxt  = r_level;
      if (flush_i) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_level_nxt  = '0;
      end else begin
         if (w_wr) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
         if (w_rd) w_rd_ptr_nxt = r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
         endcase
      end
      // The RAM read of the next head returns pre-write data, so a word landing on the head slot is bypassed
      w_byp = w_wr && (r_wr_ptr == w_rd_ptr_nxt);
   end

   stream_fifo_mem #(
      .DW(DW),
      .AW(AW)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (stream_s_data_i),
      .i_rd_addr (w_rd_ptr_nxt),
      .o_rd_data (w_mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_s_ready  <= 1'b0;
         r_m_valid  <= 1'b0;
         r_af       <= 1'b0;
         r_ae       <= 1'b1;
         r_ovf      <= 1'b0;
         r_byp      <= 1'b1;
         r_byp_data <= '0;
      end else begin
         r_wr_ptr  <= w_wr_ptr_nxt;
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_level   <= w_level_nxt;
         r_s_ready <= (w_level_nxt != L_DEPTH);
         r_m_valid <= (w_level_nxt != '0);
         r_af      <= (w_level_nxt >= L_AF);
         r_ae      <= (w_level_nxt <= L_AE);
         r_ovf     <= stream_s_valid_i && !r_s_ready && !flush_i;
         if (w_byp) begin
            r_byp      <= 1'b1;
            r_byp_data <= stream_s_data_i;
         end else if (w_rd || flush_i) begin
            r_byp      <= 1'b0;
         end
      end
   end

   assign stream_s_ready_o = r_s_ready;
   assign stream_m_valid_o = r_m_valid;
   assign stream_m_data_o  = r_byp ? r_byp_data : w_mem_rdata;
   assign level_o          = r_level;
   assign almost_full_o    = r_af;
   assign almost_empty_o   = r_ae;
   assign overflow_o       = r_ovf;

endmodule

// File: tb/tb_stream_sync_fifo.sv
// tb/tb_stream_sync_fifo.sv - self-checking bench for stream_sync_fifo against a queue reference model
module tb_stream_sync_fifo;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush_i = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [AW:0]   level;
   logic          afull, aempty, ovf;

   stream_sync_fifo #(
      .DW(DW), .AW(AW), .AF_LVL(AF), .AE_LVL(AE)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush_i          (flush_i),
      .stream_s_data_i  (s_data),
      .stream_s_valid_i (s_valid),
      .stream_s_ready_o (s_ready),
      .stream_m_data_o  (m_data),
      .stream_m_valid_o (m_valid),
      .stream_m_ready_i (m_ready),
      .level_o          (level),
      .almost_full_o    (afull),
      .almost_empty_o   (aempty),
      .overflow_o       (ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   bit         mdl_rdy = 1'b0;
   bit         mdl_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      chk({tag, ".level"},  32'(level),   32'(sz));
      chk({tag, ".valid"},  32'(m_valid), 32'(sz != 0));
      chk({tag, ".ready"},  32'(s_ready), 32'(mdl_rdy));
      chk({tag, ".afull"},  32'(afull),   32'(sz >= AF));
      chk({tag, ".aempty"}, 32'(aempty),  32'(sz <= AE));
      chk({tag, ".ovf"},    32'(ovf),     32'(mdl_ovf));
      if (sz != 0) chk({tag, ".data"}, 32'(m_data), 32'(q[0]));
   endtask

   task automatic reset_check(input string tag);
      chk({tag, ".level"},  32'(level),   32'd0);
      chk({tag, ".valid"},  32'(m_valid), 32'd0);
      chk({tag, ".ready"},  32'(s_ready), 32'd0);
      chk({tag, ".afull"},  32'(afull),   32'd0);
      chk({tag, ".aempty"}, 32'(aempty),  32'd1);
      chk({tag, ".ovf"},    32'(ovf),     32'd0);
      chk({tag, ".data"},   32'(m_data),  32'd0);
   endtask

   task automatic cycle(input logic sv, input logic [7:0] sd, input logic mr, input logic fl,
                        input string tag);
      bit wr, rd, nxt_ovf;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      flush_i = fl;
      wr      = sv && mdl_rdy && !fl;
      rd      = (q.size() != 0) && mr && !fl;
      nxt_ovf = sv && !mdl_rdy && !fl;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (rd) void'(q.pop_front());
         if (wr) q.push_back(sd);
      end
      mdl_rdy = (q.size() != DEPTH);
      mdl_ovf = nxt_ovf;
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic model_reset();
      q.delete();
      mdl_rdy = 1'b0;
      mdl_ovf = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      model_reset();
      @(negedge clk);
      #2;
      reset_check("rst0");
      @(negedge clk);
      rst_n = 1'b1;
      check_all("post_rst");
      cycle(0, 8'h00, 0, 0, "ready_rise");
      chk("ready_rise.explicit", 32'(s_ready), 32'd1);

      cycle(1, 8'h11, 0, 0, "fill1");
      cycle(1, 8'h22, 0, 0, "fill2");
      cycle(1, 8'h33, 0, 0, "fill3");
      chk("fill3.afull_at3", 32'(afull), 32'd1);
      cycle(1, 8'h44, 0, 0, "fill4");
      chk("fill4.level4", 32'(level), 32'd4);
      chk("fill4.not_ready", 32'(s_ready), 32'd0);
      cycle(1, 8'h55, 0, 0, "ovf_try");
      chk("ovf_try.pulse", 32'(ovf), 32'd1);
      cycle(0, 8'h00, 0, 0, "ovf_clear");
      chk("ovf_clear.low", 32'(ovf), 32'd0);

      for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0, "drain");
      chk("drain.empty_valid", 32'(m_valid), 32'd0);

      cycle(1, 8'hA5, 0, 0, "fwft");
      chk("fwft.valid", 32'(m_valid), 32'd1);
      chk("fwft.data", 32'(m_data), 32'hA5);
      cycle(0, 8'h00, 0, 0, "fwft_hold");
      cycle(0, 8'h00, 1, 0, "fwft_drain");

      cycle(1, 8'h00, 0, 0, "pre1");
      cycle(1, 8'h01, 0, 0, "pre2");
      d = 8'h02;
      for (int i = 0; i < 100; i++) begin
         cycle(1, d, 1, 0, "stream");
         d = d + 8'h01;
      end
      chk("stream.level_const", 32'(level), 32'd2);
      cycle(0, 8'h00, 1, 0, "stream_drain1");
      cycle(1, 8'hC3, 1, 0, "lvl1_rw");
      chk("lvl1_rw.data", 32'(m_data), 32'hC3);
      cycle(0, 8'h00, 1, 0, "stream_drain2");

      cycle(1, 8'h01, 0, 0, "ffill1");
      cycle(1, 8'h02, 0, 0, "ffill2");
      cycle(1, 8'h03, 0, 0, "ffill3");
      cycle(1, 8'h77, 1, 1, "flush");
      chk("flush.level0", 32'(level), 32'd0);
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, "post_flush");

      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0), "rand");

      cycle(0, 8'h00, 0, 1, "pre_rst_flush");
      cycle(1, 8'h61, 0, 0, "mid1");
      cycle(1, 8'h62, 0, 0, "mid2");
      s_valid = 1'b1;
      s_data  = 8'h63;
      #2;
      rst_n = 1'b0;
      #1;
      reset_check("async_rst");
      model_reset();
      @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b1;
      check_all("rst_release");
      cycle(0, 8'h00, 0, 0, "rst_idle");
      cycle(1, 8'h5A, 0, 0, "post_rst_wr");
      chk("post_rst_wr.data", 32'(m_data), 32'h5A);
      cycle(0, 8'h00, 1, 0, "post_rst_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
